// File: rtl/dmem_pkg.sv
// +--------------------------------------------------------------------------+
// | dmem_pkg: access-size encodings and FSM state codes for data_memory_ls.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;
endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// +--------------------------------------------------------------------------+
// | dmem_lane_align: byte-lane mask, store replication, load extraction.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wd,
  input  logic [31:0] rword,
  output logic [3:0]  lane_mask,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [15:0] shifted;

  // Store data is replicated across lanes so the mask alone picks the target lanes.
  always_comb begin
    lane_mask = 4'b1111;
    wdata     = wd;
    ldata     = rword;
    misalign  = 1'b0;
    shifted   = '0;
    case (size)
      SZ_BYTE: begin
        lane_mask = 4'b0001 << offset;
        wdata     = {4{wd[7:0]}};
        shifted   = 16'(rword >> {offset, 3'b000});
        ldata     = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        lane_mask = offset[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{wd[15:0]}};
        shifted   = 16'(rword >> {offset[1], 4'b0000});
        ldata     = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        misalign  = offset[0];
      end
      default: begin
        misalign = (offset != 2'b00) || (size == SZ_RSVD);
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_memory_ls.sv
// +--------------------------------------------------------------------------+
// | data_memory_ls: byte/half/word data memory with req/ready/rvalid.        |
// | Optional macro DMEM_MISALIGN_TRAP_EN enables misalignment faults. Rev 1.0|
// +--------------------------------------------------------------------------+
`default_nettype none

module data_memory_ls
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rd,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  logic [31:0]   mem [DEPTH] = '{default: '0};
  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   resp_data_q;
  logic          fault_q;

  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [3:0]    lane_mask;
  logic [31:0]   wdata;
  logic [31:0]   ldata;
  logic          misalign;
  logic          fault;
  logic          accept;
  logic [31:0]   resp_data;
  logic          unused_bits;

  assign idx         = a[AW+1:2];
  assign rword       = mem[idx];
  assign ready       = (state == IDLE);
  assign rvalid      = (state == RESP);
  assign accept      = req && ready && !reset;
  assign unused_bits = ^{a[31:AW+2], misalign};

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault = misalign;
`else
  assign fault = 1'b0;
`endif

  assign resp_data = (we || fault) ? 32'd0 : ldata;

  dmem_lane_align u_align (
    .offset    (a[1:0]),
    .size      (size),
    .sign_ext  (sign_ext),
    .wd        (wd),
    .rword     (rword),
    .lane_mask (lane_mask),
    .wdata     (wdata),
    .ldata     (ldata),
    .misalign  (misalign)
  );

  // Stores commit on the acceptance edge, so a following load always sees them.
  always_ff @(posedge clk) begin
    if (accept && we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rd          <= '0;
      err         <= 1'b0;
      resp_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            resp_data_q <= resp_data;
            fault_q     <= fault;
            if (LATENCY == 1) begin
              state <= RESP;
              rd    <= resp_data;
              err   <= fault;
            end else begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= RESP;
            rd    <= resp_data_q;
            err   <= fault_q;
          end
        end
        RESP: begin
          state <= IDLE;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_ls.sv
// +--------------------------------------------------------------------------+
// | tb_data_memory_ls: directed self-checking bench, LATENCY=1 and LATENCY=3.|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_data_memory_ls;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset1, reset3, req1, req3, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] a, wd;
  logic        ready1, rvalid1, err1, ready3, rvalid3, err3;
  logic [31:0] rd1, rd3;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  data_memory_ls #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset1), .req(req1), .we(we), .size(size), .sign_ext(sign_ext),
    .a(a), .wd(wd), .ready(ready1), .rvalid(rvalid1), .rd(rd1), .err(err1)
  );

  data_memory_ls #(.DEPTH(64), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset3), .req(req3), .we(we), .size(size), .sign_ext(sign_ext),
    .a(a), .wd(wd), .ready(ready3), .rvalid(rvalid3), .rd(rd3), .err(err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access on DUT d; latency counts negedges after the accepting posedge.
  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic e, output int lat);
    @(negedge clk);
    we = w; size = sz; sign_ext = sx; a = addr; wd = data;
    if (d == 1) req1 = 1'b1; else req3 = 1'b1;
    @(negedge clk);
    req1 = 1'b0; req3 = 1'b0;
    lat = 0; rdata = 'x; e = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      if ((d == 1) ? rvalid1 : rvalid3) begin
        lat   = c;
        rdata = (d == 1) ? rd1 : rd3;
        e     = (d == 1) ? err1 : err3;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic op(input string tag, input int d, input logic w, input logic [1:0] sz,
                    input logic sx, input logic [31:0] addr, input logic [31:0] data,
                    input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] r;
    logic        e;
    int          lat;
    access(d, w, sz, sx, addr, data, r, e, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rd"}, r, exp_rd);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset1 = 1'b1; reset3 = 1'b1; req1 = 1'b0; req3 = 1'b0;
    we = 1'b0; size = SZ_WORD; sign_ext = 1'b0; a = '0; wd = '0;
    repeat (2) @(negedge clk);
    reset1 = 1'b0; reset3 = 1'b0;
    check("rst_ready", {31'd0, ready1}, 32'd1);
    check("rst_rvalid", {31'd0, rvalid1}, 32'd0);
    check("rst_rd", rd1, 32'd0);
    check("rst_err", {31'd0, err1}, 32'd0);

    op("sw10",   1, 1, SZ_WORD, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 1);
    op("lw10",   1, 0, SZ_WORD, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1);
    op("sw10z",  1, 1, SZ_WORD, 0, 32'h10,  32'h0,        32'h0,        0, 1);
    op("sb13",   1, 1, SZ_BYTE, 0, 32'h13,  32'h80,       32'h0,        0, 1);
    op("lw10b",  1, 0, SZ_WORD, 0, 32'h10,  32'h0,        32'h80000000, 0, 1);
    op("lb13",   1, 0, SZ_BYTE, 1, 32'h13,  32'h0,        32'hFFFFFF80, 0, 1);
    op("lbu13",  1, 0, SZ_BYTE, 0, 32'h13,  32'h0,        32'h00000080, 0, 1);
    op("sh12",   1, 1, SZ_HALF, 0, 32'h12,  32'h8234,     32'h0,        0, 1);
    op("lw10h",  1, 0, SZ_WORD, 0, 32'h10,  32'h0,        32'h82340000, 0, 1);
    op("lh12",   1, 0, SZ_HALF, 1, 32'h12,  32'h0,        32'hFFFF8234, 0, 1);
    op("lhu12",  1, 0, SZ_HALF, 0, 32'h12,  32'h0,        32'h00008234, 0, 1);
    op("sw100",  1, 1, SZ_WORD, 0, 32'h100, 32'hCAFEF00D, 32'h0,        0, 1);
    op("lw0",    1, 0, SZ_WORD, 0, 32'h0,   32'h0,        32'hCAFEF00D, 0, 1);
    @(negedge clk);
    check("rd_hold", rd1, 32'hCAFEF00D);
    check("rvalid_pulse", {31'd0, rvalid1}, 32'd0);

    op("sw20",   1, 1, SZ_WORD, 0, 32'h20,  32'h11223344, 32'h0,        0, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    op("sh21",   1, 1, SZ_HALF, 0, 32'h21,  32'hAABB,     32'h0,        1, 1);
    op("lw20m",  1, 0, SZ_WORD, 0, 32'h20,  32'h0,        32'h11223344, 0, 1);
    op("lw22",   1, 0, SZ_WORD, 0, 32'h22,  32'h0,        32'h0,        1, 1);
    op("lrsvd",  1, 0, SZ_RSVD, 0, 32'h20,  32'h0,        32'h0,        1, 1);
`else
    op("sh21",   1, 1, SZ_HALF, 0, 32'h21,  32'hAABB,     32'h0,        0, 1);
    op("lw20m",  1, 0, SZ_WORD, 0, 32'h20,  32'h0,        32'h1122AABB, 0, 1);
    op("lw22",   1, 0, SZ_WORD, 0, 32'h22,  32'h0,        32'h1122AABB, 0, 1);
    op("lrsvd",  1, 0, SZ_RSVD, 0, 32'h20,  32'h0,        32'h1122AABB, 0, 1);
`endif

    op("l3_sw4", 3, 1, SZ_WORD, 0, 32'h4,   32'h0BADF00D, 32'h0,        0, 3);
    @(negedge clk);
    we = 1'b0; size = SZ_WORD; sign_ext = 1'b0; a = 32'h4; req3 = 1'b1;
    @(negedge clk);
    check("l3_c1_ready", {31'd0, ready3}, 32'd0);
    check("l3_c1_rvalid", {31'd0, rvalid3}, 32'd0);
    @(negedge clk);
    req3 = 1'b0;
    check("l3_c2_ready", {31'd0, ready3}, 32'd0);
    check("l3_c2_rvalid", {31'd0, rvalid3}, 32'd0);
    @(negedge clk);
    check("l3_c3_ready", {31'd0, ready3}, 32'd0);
    check("l3_c3_rvalid", {31'd0, rvalid3}, 32'd1);
    check("l3_c3_rd", rd3, 32'h0BADF00D);
    @(negedge clk);
    check("l3_c4_ready", {31'd0, ready3}, 32'd1);
    check("l3_c4_rvalid", {31'd0, rvalid3}, 32'd0);
    @(negedge clk);
    check("l3_noqueue_ready", {31'd0, ready3}, 32'd1);
    check("l3_noqueue_rvalid", {31'd0, rvalid3}, 32'd0);

    @(negedge clk);
    we = 1'b1; size = SZ_WORD; a = 32'h30; wd = 32'h55AA55AA; req3 = 1'b1;
    @(negedge clk);
    req3 = 1'b0; reset3 = 1'b1;
    @(negedge clk);
    reset3 = 1'b0;
    check("mrst_ready", {31'd0, ready3}, 32'd1);
    check("mrst_rvalid", {31'd0, rvalid3}, 32'd0);
    @(negedge clk);
    check("mrst_norv", {31'd0, rvalid3}, 32'd0);
    op("mrst_lw30", 3, 0, SZ_WORD, 0, 32'h30, 32'h0, 32'h55AA55AA, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
